uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Shares one PISO UART transmitter between NUM_REQ byte requesters using round-robin arbitration.
- Latches the granted byte and computes its parity bit.
- Drives the PISO send/data/parity inputs and tracks the PISO active flag until the frame completes, then acknowledges the requester.
- Sits between the application-side message producers and the PISO on the baud clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ODD_PARITY, 0, 0 selects even parity (parity = XOR of data); 1 selects odd parity (inverted XOR).
- START_TIMEOUT, 8, baud_clk cycles to wait for piso_active after send before aborting.

Ports:
- baud_clk  in  1  baud-rate clock shared with the PISO.
- reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester transmit request; held high until ack.
- req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- ack  out  NUM_REQ  one-hot, one-cycle pulse: byte of that requester fully sent.
- err  out  NUM_REQ  one-hot, one-cycle pulse: start timeout for that requester.
- piso_send  out  1  to PISO send.
- piso_data  out  8  to PISO data_in; stable for the whole frame.
- piso_parity  out  1  to PISO parity_bit; stable for the whole frame.
- piso_active  in  1  from PISO active_flag.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset_n low at a baud_clk edge) values:
  - state=IDLE, rr_ptr=0.
  - ack=0, err=0, piso_send=0, piso_data=0x00, piso_parity=0, busy=0.
  - Timeout counter = 0.
  - Reset mid-frame is legal: the scheduler drops the frame without ack, and the PISO is reset by the same reset_n.
- States: IDLE, SEND, BUSY, DONE.
- IDLE:
  - If any req bit is high, grant the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Latch grant_id, piso_data=req_data[grant_id] and piso_parity.
  - Set piso_send=1 and go to SEND.
  - If no req is high, stay in IDLE.
- SEND:
  - piso_send stays 1 and the counter increments each cycle.
  - If piso_active==1: piso_send=0, clear the counter, go to BUSY.
  - Else if counter==START_TIMEOUT-1: piso_send=0, pulse err[grant_id], rr_ptr=grant_id+1 (wrap), go to IDLE.
- BUSY:
  - Wait for piso_active==0, i.e. the PISO has finished 11 bit times.
  - Then go to DONE.
- DONE (one cycle):
  - Pulse ack[grant_id].
  - rr_ptr = grant_id+1, wrapped modulo NUM_REQ.
  - Go to IDLE.
  - A requester that sees ack must drop req or present its next byte on the following cycle.
  - The earliest re-grant is the cycle after DONE, so a requester that keeps req high gets back-to-back frames only when no other requester is pending.
- Latency:
  - Grant to piso_send high: 1 cycle (registered).
  - Nominal grant to ack pulse: 15 cycles (send 1, PISO accept 2, 11 frame bits, DONE 1).
  - The bench checks a window of 14..16 cycles.
- Requests:
  - Deasserting req, or changing req_data, after the grant has no effect on the in-flight frame; the frame still completes and acks.
  - Simultaneous requests are served strictly round-robin with no starvation; worst-case wait is (NUM_REQ-1) frames.
  - Requests arriving while not in IDLE wait; they are never lost while held.
- Outputs are registered. ack and err are never high together. At most one bit of ack|err is high in any cycle.
- The timeout counter width is clog2(START_TIMEOUT)+1; it saturates and never wraps.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants (IDLE/SEND/BUSY/DONE);
  - UART_FRAME_BITS=11 and UART_DATA_BITS=8;
  - parity function parity_calc(data, odd).
- Sub-module rr_arbiter (NUM_REQ parameter): inputs req and rr_ptr; outputs grant_valid and grant_id. Purely combinational priority rotate.
- The FSM, latching and timeout stay in uart_tx_scheduler.
- Top-level integration instantiates the PISO alongside; the PISO is not a sub-module of this block.

Test Plan:
- Single requester: req[0]=1, data0=0xA5, ODD_PARITY=0 -> piso_data=0xA5 and piso_parity=0 (four ones); PISO serial line carries 0,1,0,1,0,0,1,0,1,0,1; ack[0] pulses once, 14..16 cycles after the grant.
- Contention: req=4'b1111 with bytes 0x11,0x22,0x33,0x44, all held -> frames sent in order 0,1,2,3 then 0 again; each ack is one cycle; piso_data never changes while piso_active=1.
- Round-robin pointer: after serving req 2, assert req=4'b0101 -> requester 0 is granted next (pointer at 3 wraps to 0), then requester 2.
- Odd parity: ODD_PARITY=1, data=0x07 -> piso_parity=0; data=0x03 -> piso_parity=1.
- Timeout: PISO stubbed with piso_active tied 0, req[1]=1 -> piso_send high for exactly 8 cycles; err[1] pulses once; no ack; state returns to IDLE; the next grant goes to requester 2 if it is requesting.
- Mid-frame reset: reset_n=0 for 1 cycle while BUSY -> next cycle busy=0, piso_send=0, ack=0; the held req is re-granted after reset releases, and the frame is sent in full.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
// State encoding, frame geometry and the parity helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int UART_FRAME_BITS = 11;
    localparam int UART_DATA_BITS  = 8;

    function automatic logic parity_calc(
        input logic [UART_DATA_BITS-1:0] data,
        input logic                      odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and PISO-side bundle of the UART transmit scheduler.
// master = scheduler side, slave = requesters plus PISO side.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   err;
    logic                 piso_send;
    logic [7:0]           piso_data;
    logic                 piso_parity;
    logic                 piso_active;

    modport master (
        input  req, req_data, piso_active,
        output ack, err, piso_send, piso_data, piso_parity
    );

    modport slave (
        output req, req_data, piso_active,
        input  ack, err, piso_send, piso_data, piso_parity
    );
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first set request at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      rr_ptr,
    output logic               grant_valid,
    output logic [PW-1:0]      grant_id
);

    int            w_idx;
    logic [PW-1:0] w_sel;

    // Walk from the farthest offset down so the nearest hit wins
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        w_idx       = 0;
        w_sel       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(rr_ptr) + k) % NUM_REQ;
            w_sel = PW'(w_idx);
            if (req[w_sel]) begin
                grant_valid = 1'b1;
                grant_id    = w_sel;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one PISO UART transmitter between NUM_REQ byte requesters.
// Round-robin grant, byte/parity latch, start timeout and ack/err pulses.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ODD_PARITY    = 0,
    parameter int START_TIMEOUT = 8
) (
    input  logic                  baud_clk,
    input  logic                  reset_n,
    uart_tx_scheduler_if.master   bus,
    output logic                  busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(START_TIMEOUT) + 1;

    state_t             r_state, w_state;
    logic [PW-1:0]      r_ptr, w_ptr;
    logic [PW-1:0]      r_gid, w_gid;
    logic [CW-1:0]      r_cnt, w_cnt;
    logic [7:0]         r_data, w_data;
    logic               r_par, w_par;
    logic               r_send, w_send;
    logic [NUM_REQ-1:0] r_ack, w_ack;
    logic [NUM_REQ-1:0] r_err, w_err;

    logic               w_gnt_valid;
    logic [PW-1:0]      w_gnt_id;
    logic [7:0]         w_sel_byte;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req         (bus.req),
        .rr_ptr      (r_ptr),
        .grant_valid (w_gnt_valid),
        .grant_id    (w_gnt_id)
    );

    assign w_sel_byte = bus.req_data[{w_gnt_id, 3'b000} +: 8];

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_gid   = r_gid;
        w_cnt   = r_cnt;
        w_data  = r_data;
        w_par   = r_par;
        w_send  = r_send;
        w_ack   = '0;
        w_err   = '0;
        unique case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_gid   = w_gnt_id;
                    w_data  = w_sel_byte;
                    w_par   = parity_calc(w_sel_byte, ODD_PARITY != 0);
                    w_send  = 1'b1;
                    w_cnt   = '0;
                    w_state = SEND;
                end
            end
            SEND: begin
                if (bus.piso_active) begin
                    w_send  = 1'b0;
                    w_cnt   = '0;
                    w_state = BUSY;
                end else if (r_cnt == CW'(START_TIMEOUT - 1)) begin
                    w_send       = 1'b0;
                    w_cnt        = '0;
                    w_err[r_gid] = 1'b1;
                    w_ptr        = f_next(r_gid);
                    w_state      = IDLE;
                end else if (r_cnt != '1) begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            // ack is registered so it is visible during DONE
            BUSY: begin
                if (!bus.piso_active) begin
                    w_ack[r_gid] = 1'b1;
                    w_state      = DONE;
                end
            end
            DONE: begin
                w_ptr   = f_next(r_gid);
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_par   <= 1'b0;
            r_send  <= 1'b0;
            r_ack   <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_gid   <= w_gid;
            r_cnt   <= w_cnt;
            r_data  <= w_data;
            r_par   <= w_par;
            r_send  <= w_send;
            r_ack   <= w_ack;
            r_err   <= w_err;
        end
    end

    assign bus.ack         = r_ack;
    assign bus.err         = r_err;
    assign bus.piso_send   = r_send;
    assign bus.piso_data   = r_data;
    assign bus.piso_parity = r_par;
    assign busy            = (r_state != IDLE);

endmodule
